// File: rtl/core_pkg.sv
// Shared constants, FSM state encoding and opcode helpers for the RISC core control path.
package core_pkg;

    localparam int         PC_W     = 9;
    localparam logic [4:0] LINK_REG = 5'd31;

    localparam logic [5:0] OP_J    = 6'd1;
    localparam logic [5:0] OP_JR   = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory, jump-unit and link-write signals between the sequencer and its neighbours.
interface pc_sequencer_if;
    import core_pkg::*;

    logic [PC_W-1:0] imem_addr;
    logic            imem_re;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic [31:0]     inst_reg;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] jmp_new_pc;
    logic [PC_W-1:0] jmp_link;
    logic            rf_link_we;
    logic [4:0]      rf_link_addr;
    logic [31:0]     rf_link_data;

    modport master (
        output imem_addr, imem_re, inst_reg, pc, rf_link_we, rf_link_addr, rf_link_data,
        input  imem_ready, imem_rdata, jmp_new_pc, jmp_link
    );

    modport slave (
        input  imem_addr, imem_re, inst_reg, pc, rf_link_we, rf_link_addr, rf_link_data,
        output imem_ready, imem_rdata, jmp_new_pc, jmp_link
    );

endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC select: jump beats taken branch beats sequential increment (wraps).
module next_pc_mux
    import core_pkg::*;
(
    input  logic [5:0]      op_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] jmp_new_pc_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic [PC_W-1:0] next_pc_o
);

    always_comb begin
        if (is_jump_op(op_i)) begin
            next_pc_o = jmp_new_pc_i;
        end else if (br_taken_i) begin
            next_pc_o = br_target_i;
        end else begin
            next_pc_o = pc_i + PC_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and multi-cycle fetch/decode/execute/writeback control for the RISC core.
module pc_sequencer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            exec_en,
    output logic            halted,
    pc_sequencer_if.master  bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            br_q, br_d;
    logic [PC_W-1:0] next_pc;
    logic [5:0]      op;

    assign op = ir_q[31:26];

    next_pc_mux u_next_pc (
        .op_i         (op),
        .pc_i         (pc_q),
        .jmp_new_pc_i (bus.jmp_new_pc),
        .br_taken_i   (br_q),
        .br_target_i  (br_target),
        .next_pc_o    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        br_d    = br_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                // Branch condition is only meaningful while the ALU is enabled.
                br_d    = br_taken;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                pc_d    = next_pc;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.imem_re    = (state_q == ST_FETCH);
        exec_en        = (state_q == ST_EXECUTE);
        halted         = (state_q == ST_HALT);
        // A reset landing on WRITEBACK must not let the link write through.
        bus.rf_link_we = (state_q == ST_WRITEBACK) && (op == OP_JAL) && !rst;
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc           = pc_q;
    assign bus.inst_reg     = ir_q;
    assign bus.rf_link_addr = LINK_REG;
    assign bus.rf_link_data = {{(32-PC_W){1'b0}}, bus.jmp_link};

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with an instruction-level reference model.
module tb_pc_sequencer;
    import core_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            exec_en;
    logic            halted;
    logic            ready;

    int checks = 0;
    int errors = 0;

    logic [31:0]     mem    [0:(1<<PC_W)-1];
    logic [31:0]     rs_val [0:31];
    logic [PC_W-1:0] stale_pc, stale_link;
    logic [PC_W-1:0] exp_pc;
    logic [31:0]     exp_ir;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .br_taken  (br_taken),
        .br_target (br_target),
        .exec_en   (exec_en),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = mem[bus.imem_addr];
    assign bus.imem_ready = ready;

    // Jump unit stand-in: real targets for jump opcodes, stale junk otherwise.
    always_comb begin
        bus.jmp_new_pc = stale_pc;
        bus.jmp_link   = stale_link;
        case (bus.inst_reg[31:26])
            OP_J, OP_JAL: begin
                bus.jmp_new_pc = bus.inst_reg[PC_W-1:0];
                bus.jmp_link   = bus.pc + PC_W'(1);
            end
            OP_JR: begin
                bus.jmp_new_pc = rs_val[bus.inst_reg[25:21]][PC_W-1:0];
                bus.jmp_link   = bus.pc + PC_W'(1);
            end
            default: ;
        endcase
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        exp_pc = '0;
        exp_ir = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from FETCH; returns at the negedge after WRITEBACK (or in HALT).
    task automatic step_instr(input logic [31:0] instr, input logic bt,
                              input logic [PC_W-1:0] btgt, input int delay);
        logic [5:0]      op;
        logic [PC_W-1:0] want_pc;
        logic [31:0]     want_link;
        op         = instr[31:26];
        mem[exp_pc] = instr;
        br_target  = btgt;
        stale_pc   = PC_W'($urandom);
        stale_link = PC_W'($urandom);
        if (op == OP_JR)                        want_pc = rs_val[instr[25:21]][PC_W-1:0];
        else if (op == OP_J || op == OP_JAL)    want_pc = instr[PC_W-1:0];
        else if (bt)                            want_pc = btgt;
        else                                    want_pc = exp_pc + PC_W'(1);
        want_link = {{(32-PC_W){1'b0}}, PC_W'(exp_pc + PC_W'(1))};

        for (int c = 0; c <= delay; c++) begin
            ready    = (c == delay);
            br_taken = 1'($urandom);
            start    = 1'($urandom);
            checks++;
            if (bus.imem_re !== 1'b1 || bus.imem_addr !== exp_pc || bus.pc !== exp_pc)
                $display("FAIL fetch re=%0b addr=%0d pc=%0d want re=1 addr=pc=%0d",
                         bus.imem_re, bus.imem_addr, bus.pc, exp_pc);
            if (bus.imem_re !== 1'b1 || bus.imem_addr !== exp_pc || bus.pc !== exp_pc) errors++;
            checks++;
            if (bus.inst_reg !== exp_ir || exec_en !== 1'b0) begin
                errors++;
                $display("FAIL ir_hold ir=%h exec_en=%0b want ir=%h exec_en=0",
                         bus.inst_reg, exec_en, exp_ir);
            end
            @(negedge clk);
        end

        ready    = 1'($urandom);
        br_taken = 1'($urandom);
        start    = 1'($urandom);
        exp_ir   = instr;
        checks++;
        if (bus.imem_re !== 1'b0 || bus.inst_reg !== instr || exec_en !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL decode re=%0b ir=%h exec_en=%0b halted=%0b want re=0 ir=%h exec_en=0 halted=0",
                     bus.imem_re, bus.inst_reg, exec_en, halted, instr);
        end
        @(negedge clk);

        if (op != OP_HALT) begin
            ready    = 1'($urandom);
            br_taken = bt;
            start    = 1'($urandom);
            checks++;
            if (exec_en !== 1'b1 || bus.imem_re !== 1'b0 || bus.rf_link_we !== 1'b0) begin
                errors++;
                $display("FAIL execute exec_en=%0b re=%0b we=%0b want exec_en=1 re=0 we=0",
                         exec_en, bus.imem_re, bus.rf_link_we);
            end
            @(negedge clk);

            ready    = 1'($urandom);
            br_taken = 1'($urandom);
            start    = 1'($urandom);
            checks++;
            if (exec_en !== 1'b0 || bus.rf_link_we !== (op == OP_JAL)) begin
                errors++;
                $display("FAIL writeback exec_en=%0b we=%0b want exec_en=0 we=%0b",
                         exec_en, bus.rf_link_we, (op == OP_JAL));
            end
            if (op == OP_JAL) begin
                checks++;
                if (bus.rf_link_addr !== LINK_REG || bus.rf_link_data !== want_link) begin
                    errors++;
                    $display("FAIL link addr=%0d data=%0d want addr=%0d data=%0d",
                             bus.rf_link_addr, bus.rf_link_data, LINK_REG, want_link);
                end
            end
            @(negedge clk);
            start  = 1'b0;
            exp_pc = want_pc;
            checks++;
            if (bus.pc !== exp_pc || bus.imem_re !== 1'b1 || bus.rf_link_we !== 1'b0) begin
                errors++;
                $display("FAIL commit pc=%0d re=%0b we=%0b want pc=%0d re=1 we=0",
                         bus.pc, bus.imem_re, bus.rf_link_we, exp_pc);
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [PC_W-1:0] tgt);
        logic [31:0] w;
        w = {op, 26'($urandom)};
        w[PC_W-1:0] = tgt;
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; br_taken = 1'b0; br_target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.pc !== '0 || bus.inst_reg !== '0 || bus.imem_re !== 1'b0 ||
            bus.rf_link_we !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset pc=%0d ir=%h re=%0b we=%0b exec_en=%0b halted=%0b want all 0",
                     bus.pc, bus.inst_reg, bus.imem_re, bus.rf_link_we, exec_en, halted);
        end
        for (int i = 0; i < 3; i++) begin
            ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.imem_re !== 1'b0 || bus.pc !== '0) begin
                errors++;
                $display("FAIL idle_wait re=%0b pc=%0d want re=0 pc=0", bus.imem_re, bus.pc);
            end
        end
        exp_pc = '0;
        exp_ir = '0;
    endtask

    task automatic test_sequential();
        do_start();
        for (int i = 0; i < 4; i++) step_instr(mk(6'd0, PC_W'($urandom)), 1'b0, '0, 0);
    endtask

    task automatic test_fetch_stall();
        step_instr(mk(6'd0, '0), 1'b0, '0, 3);
    endtask

    task automatic test_jump();
        step_instr(mk(OP_J, 9'd40), 1'b0, '0, 0);
        step_instr(mk(OP_J, 9'd7), 1'b0, '0, 1);
    endtask

    task automatic test_jal();
        step_instr(mk(OP_JAL, 9'd100), 1'b0, '0, 0);
    endtask

    task automatic test_wrap_and_priority();
        step_instr(mk(OP_J, 9'd511), 1'b0, '0, 0);
        step_instr(mk(6'd0, '0), 1'b0, '0, 0);
        step_instr(mk(OP_J, 9'd200), 1'b1, 9'd77, 0);
        step_instr(mk(6'd9, '0), 1'b1, 9'd300, 0);
        step_instr(mk(OP_JR, '0), 1'b1, 9'd12, 2);
        step_instr(mk(OP_JAL, 9'd50), 1'b1, 9'd13, 0);
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       op = OP_J;
                1:       op = OP_JR;
                2:       op = OP_JAL;
                3:       op = 6'd0;
                default: op = 6'($urandom_range(4, 62));
            endcase
            step_instr({op, 26'($urandom)}, 1'($urandom), PC_W'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_halt();
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) step_instr(mk(6'd0, '0), 1'b0, '0, 0);
        step_instr({OP_HALT, 26'($urandom)}, 1'b0, '0, 0);
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom);
            ready = 1'($urandom);
            checks++;
            if (halted !== 1'b1 || bus.pc !== 9'd3 || bus.inst_reg !== exp_ir ||
                exec_en !== 1'b0 || bus.imem_re !== 1'b0) begin
                errors++;
                $display("FAIL halt halted=%0b pc=%0d ir=%h exec_en=%0b re=%0b want 1/3/%h/0/0",
                         halted, bus.pc, bus.inst_reg, exec_en, bus.imem_re, exp_ir);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_to_execute(input logic [31:0] instr);
        mem[exp_pc] = instr;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (exec_en !== 1'b1) begin
            errors++;
            $display("FAIL reach_exec exec_en=%0b want 1", exec_en);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        run_to_execute(mk(OP_JAL, 9'd100));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.rf_link_we !== 1'b0 || bus.pc !== '0 || bus.inst_reg !== '0 ||
                bus.imem_re !== 1'b0 || exec_en !== 1'b0) begin
                errors++;
                $display("FAIL rst_exec we=%0b pc=%0d ir=%h re=%0b exec_en=%0b want all 0",
                         bus.rf_link_we, bus.pc, bus.inst_reg, bus.imem_re, exec_en);
            end
            @(negedge clk);
        end
        exp_pc = '0;
        exp_ir = '0;
        do_start();
        run_to_execute(mk(OP_JAL, 9'd100));
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rf_link_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_we we=%0b want 0", bus.rf_link_we);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.pc !== '0 || bus.imem_re !== 1'b0 || bus.rf_link_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb pc=%0d re=%0b we=%0b want pc=0 re=0 we=0",
                     bus.pc, bus.imem_re, bus.rf_link_we);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; br_taken = 1'b0; br_target = '0;
        stale_pc = '0; stale_link = '0;
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = '0;
        for (int i = 0; i < 32; i++) rs_val[i] = $urandom;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_fetch_stall();
        test_jump();
        test_jal();
        test_wrap_and_priority();
        test_random();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
